// File: rtl/merge_sort_pkg.sv
// Shared types and helpers for the merge-sort scheduler.
// Holds the FSM state enum, default sizes and the lane unpacker.
package merge_sort_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_BEATS   = 8;
  localparam int DEF_OUT_LEN = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    FEED,
    WAIT,
    DRAIN
  } state_t;

  typedef struct packed {
    logic signed [DEF_W-1:0] l3;
    logic signed [DEF_W-1:0] l2;
    logic signed [DEF_W-1:0] l1;
    logic signed [DEF_W-1:0] l0;
  } lanes_t;

  function automatic lanes_t unpack_lanes(
    input logic [4*DEF_W-1:0] d
  );
    lanes_t r;
    r.l0 = d[DEF_W-1:0];
    r.l1 = d[2*DEF_W-1:DEF_W];
    r.l2 = d[3*DEF_W-1:2*DEF_W];
    r.l3 = d[4*DEF_W-1:3*DEF_W];
    return r;
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker.
// Remembers the last winner; the other side wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       any
);

  logic last_grant;

  assign any = |req;
  assign gnt = req[1] && (!req[0] || !last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (take && any) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/merge_sort_scheduler.sv
// Shares one 4-lane merge-sort engine between two requesters.
// Feeds a block of beats, then routes the sorted burst back.
module merge_sort_scheduler
  import merge_sort_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int BEATS   = DEF_BEATS,
  parameter int OUT_LEN = DEF_OUT_LEN,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [4*W-1:0] req0_data,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [4*W-1:0] req1_data,
  output logic           req1_ready,
  output logic           res0_valid,
  output logic [W-1:0]   res0_data,
  output logic           res0_last,
  output logic           res1_valid,
  output logic [W-1:0]   res1_data,
  output logic           res1_last,
  output logic [W-1:0]   eng_in1,
  output logic [W-1:0]   eng_in2,
  output logic [W-1:0]   eng_in3,
  output logic [W-1:0]   eng_in4,
  output logic           eng_blk_in,
  input  logic [W-1:0]   eng_sort_out,
  input  logic           eng_out_valid,
  output logic           busy,
  output logic           grant,
  output logic           underrun_err,
  output logic           short_err,
  output logic           timeout_err
);

  localparam int CW = $clog2(max3(BEATS, OUT_LEN, TIMEOUT)) + 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] OUT_LAST  = CW'(OUT_LEN - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

  state_t         state;
  logic [CW-1:0]  beat_cnt;
  logic [CW-1:0]  out_cnt;
  logic [CW-1:0]  tmo_cnt;
  logic           arb_gnt;
  logic           arb_any;
  logic           g_valid;
  logic [4*W-1:0] g_data;
  lanes_t         g_lanes;
  logic           fwd;
  logic           last_hit;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({req1_valid, req0_valid}),
    .take (state == IDLE),
    .gnt  (arb_gnt),
    .any  (arb_any)
  );

  assign g_valid = grant ? req1_valid : req0_valid;
  assign g_data  = grant ? req1_data : req0_data;
  assign g_lanes = unpack_lanes(g_data);

  assign busy       = (state != IDLE);
  assign req0_ready = (state == FEED) && !grant;
  assign req1_ready = (state == FEED) && grant;

  // Results bypass any register so the engine sees zero added latency.
  assign fwd        = eng_out_valid &&
                      (state == WAIT || state == DRAIN);
  assign last_hit   = fwd && (out_cnt == OUT_LAST);
  assign res0_valid = fwd && !grant;
  assign res1_valid = fwd && grant;
  assign res0_data  = res0_valid ? eng_sort_out : '0;
  assign res1_data  = res1_valid ? eng_sort_out : '0;
  assign res0_last  = last_hit && !grant;
  assign res1_last  = last_hit && grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      out_cnt      <= '0;
      tmo_cnt      <= '0;
      grant        <= 1'b0;
      eng_blk_in   <= 1'b0;
      eng_in1      <= '0;
      eng_in2      <= '0;
      eng_in3      <= '0;
      eng_in4      <= '0;
      underrun_err <= 1'b0;
      short_err    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      eng_blk_in   <= 1'b0;
      eng_in1      <= '0;
      eng_in2      <= '0;
      eng_in3      <= '0;
      eng_in4      <= '0;
      underrun_err <= 1'b0;
      short_err    <= 1'b0;
      timeout_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            grant      <= arb_gnt;
            eng_blk_in <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          beat_cnt <= '0;
          state    <= FEED;
        end
        FEED: begin
          // The engine cannot stall, so a missing beat becomes zeros.
          if (g_valid) begin
            eng_in1 <= g_lanes.l0;
            eng_in2 <= g_lanes.l1;
            eng_in3 <= g_lanes.l2;
            eng_in4 <= g_lanes.l3;
          end else begin
            underrun_err <= 1'b1;
          end
          if (beat_cnt == BEAT_LAST) begin
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= WAIT;
          end else begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        WAIT: begin
          if (eng_out_valid) begin
            tmo_cnt <= '0;
            if (OUT_LEN == 1) begin
              out_cnt <= '0;
              state   <= IDLE;
            end else begin
              out_cnt <= CW'(1);
              state   <= DRAIN;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (!eng_out_valid) begin
            out_cnt   <= '0;
            short_err <= 1'b1;
            state     <= IDLE;
          end else if (out_cnt == OUT_LAST) begin
            out_cnt <= '0;
            state   <= IDLE;
          end else begin
            out_cnt <= out_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_sort_scheduler.sv
// Directed bench for merge_sort_scheduler.
// Table of block scenarios plus hand sequences for reset and contention.
module tb_merge_sort_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        res0_valid, res0_last;
  logic [7:0]  res0_data;
  logic        res1_valid, res1_last;
  logic [7:0]  res1_data;
  logic [7:0]  eng_in1, eng_in2, eng_in3, eng_in4;
  logic        eng_blk_in;
  logic [7:0]  eng_sort_out = '0;
  logic        eng_out_valid = 1'b0;
  logic        busy, grant;
  logic        underrun_err, short_err, timeout_err;

  merge_sort_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .res0_valid    (res0_valid),
    .res0_data     (res0_data),
    .res0_last     (res0_last),
    .res1_valid    (res1_valid),
    .res1_data     (res1_data),
    .res1_last     (res1_last),
    .eng_in1       (eng_in1),
    .eng_in2       (eng_in2),
    .eng_in3       (eng_in3),
    .eng_in4       (eng_in4),
    .eng_blk_in    (eng_blk_in),
    .eng_sort_out  (eng_sort_out),
    .eng_out_valid (eng_out_valid),
    .busy          (busy),
    .grant         (grant),
    .underrun_err  (underrun_err),
    .short_err     (short_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Event counters, sampled on the falling edge.
  int c_blk = 0, c_und = 0, c_tmo = 0, c_short = 0;
  int c_rv0 = 0, c_rv1 = 0, c_rl0 = 0, c_rl1 = 0;
  int c_rdy0 = 0, c_rdy1 = 0, c_both = 0;

  always @(negedge clk) begin
    c_blk   += int'(eng_blk_in);
    c_und   += int'(underrun_err);
    c_tmo   += int'(timeout_err);
    c_short += int'(short_err);
    c_rv0   += int'(res0_valid);
    c_rv1   += int'(res1_valid);
    c_rl0   += int'(res0_last);
    c_rl1   += int'(res1_last);
    c_rdy0  += int'(req0_ready);
    c_rdy1  += int'(req1_ready);
    c_both  += int'(req0_ready & req1_ready);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {4'b0, busy, grant, eng_blk_in, req0_ready, req1_ready,
            res0_valid, res1_valid, res0_last, res1_last,
            underrun_err, short_err, timeout_err,
            eng_in4, eng_in3, eng_in2, eng_in1, res1_data, res0_data};
  endfunction

  task automatic drive_req(input int who, input logic v,
                           input logic [31:0] d);
    if (who == 0) begin
      req0_valid = v;
      req0_data  = d;
    end else begin
      req1_valid = v;
      req1_data  = d;
    end
  endtask

  function automatic logic ready_of(input int who);
    return (who == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic [31:0] eng_bus();
    return {eng_in4, eng_in3, eng_in2, eng_in1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          who;
    logic [31:0] data;
    logic [31:0] inc;
    int          ub;
    int          dly;
    int          eng_n;
    int          e_res;
    int          e_last;
    int          e_und;
    int          e_short;
    int          e_tmo;
  } vec_t;

  vec_t vecs[7];

  task automatic run_block(input vec_t v);
    int s_blk, s_und, s_tmo, s_short, s_rv0, s_rv1, s_rl0, s_rl1;
    int s_oth, tmo_at;
    logic [31:0] exp_b;
    logic        rv, rl;
    logic [7:0]  rd;
    s_blk = c_blk; s_und = c_und; s_tmo = c_tmo; s_short = c_short;
    s_rv0 = c_rv0; s_rv1 = c_rv1; s_rl0 = c_rl0; s_rl1 = c_rl1;
    s_oth = (v.who == 0) ? c_rdy1 : c_rdy0;
    drive_req(v.who, 1'b1, v.data);
    #1;
    chk("idle_ready", 64'(ready_of(v.who)), 64'd0);
    tick();
    chk("launch_blk", 64'(eng_blk_in), 64'd1);
    chk("launch_grant", 64'(grant), 64'(v.who));
    chk("launch_eng_in", 64'(eng_bus()), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("feed_ready", 64'(ready_of(v.who)), 64'd1);
      if (k > 0) begin
        exp_b = (k - 1 == v.ub) ? 32'd0 : v.data + v.inc * (k - 1);
        chk("feed_eng_in", 64'(eng_bus()), 64'(exp_b));
        chk("feed_underrun", 64'(underrun_err), 64'(k - 1 == v.ub));
      end
      drive_req(v.who, (k != v.ub), v.data + v.inc * k);
    end
    tick();
    exp_b = (v.ub == 7) ? 32'd0 : v.data + v.inc * 7;
    chk("wait_eng_in", 64'(eng_bus()), 64'(exp_b));
    drive_req(v.who, 1'b0, 32'd0);
    tmo_at = -1;
    for (int j = 1; j <= v.dly; j++) begin
      tick();
      if (timeout_err && tmo_at < 0) tmo_at = j;
    end
    for (int s = 0; s < v.eng_n; s++) begin
      if (s > 0) tick();
      eng_out_valid = 1'b1;
      eng_sort_out  = 8'(8 - s);
      #1;
      rv = (v.who == 0) ? res0_valid : res1_valid;
      rd = (v.who == 0) ? res0_data : res1_data;
      rl = (v.who == 0) ? res0_last : res1_last;
      chk("res_valid", 64'(rv), 64'd1);
      chk("res_data", 64'(rd), 64'(8 - s));
      chk("res_last", 64'(rl), 64'(s == 7));
    end
    tick();
    eng_out_valid = 1'b0;
    tick();
    tick();
    chk("end_busy", 64'(busy), 64'd0);
    chk("tmo_at", 64'(tmo_at), 64'(v.e_tmo ? 64 : -1));
    chk("blk_pulses", 64'(c_blk - s_blk), 64'd1);
    chk("und_pulses", 64'(c_und - s_und), 64'(v.e_und));
    chk("tmo_pulses", 64'(c_tmo - s_tmo), 64'(v.e_tmo));
    chk("short_pulses", 64'(c_short - s_short), 64'(v.e_short));
    chk("res_cnt_own", 64'((v.who == 0) ? c_rv0 - s_rv0 : c_rv1 - s_rv1),
        64'(v.e_res));
    chk("res_cnt_oth", 64'((v.who == 0) ? c_rv1 - s_rv1 : c_rv0 - s_rv0),
        64'd0);
    chk("last_cnt", 64'((c_rl0 - s_rl0) + (c_rl1 - s_rl1)),
        64'(v.e_last));
    chk("oth_ready", 64'(((v.who == 0) ? c_rdy1 : c_rdy0) - s_oth), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : main
    int s_rv0, s_rv1, s_rl0, s_rl1, s_r0, s_r1, n;
    int exp_g[3];
    //            who data           inc           ub dly en res lst und sh tmo
    vecs[0] = '{0, 32'h08FD_0500, 32'h0,        -1, 2,  8, 8, 1, 0, 0, 0};
    vecs[1] = '{1, 32'h7F80_0102, 32'h0101_0101, -1, 0, 8, 8, 1, 0, 0, 0};
    vecs[2] = '{0, 32'h1122_3344, 32'h0000_0010, 3, 3,  8, 8, 1, 1, 0, 0};
    vecs[3] = '{0, 32'hA0B0_C0D0, 32'h0,        -1, 70, 0, 0, 0, 0, 0, 1};
    vecs[4] = '{1, 32'h0102_0304, 32'h0100_0000, -1, 1, 5, 5, 0, 0, 1, 0};
    vecs[5] = '{0, 32'hFFFE_FDFC, 32'h0000_0001, -1, 63, 8, 8, 1, 0, 0, 0};
    vecs[6] = '{1, 32'h5555_AAAA, 32'h0001_0000, 7, 4,  8, 8, 1, 1, 0, 0};

    do_reset();
    chk("reset_outs", all_outs(), 64'd0);

    // Engine activity while idle must not leak to either requester.
    s_rv0 = c_rv0; s_rv1 = c_rv1;
    eng_out_valid = 1'b1;
    eng_sort_out  = 8'h33;
    tick();
    tick();
    eng_out_valid = 1'b0;
    tick();
    chk("idle_eng_ignored", 64'((c_rv0 - s_rv0) + (c_rv1 - s_rv1)), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    foreach (vecs[i]) run_block(vecs[i]);

    // Contention: both requesters hold valid for three blocks.
    rst = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 32'h0101_0101;
    req1_valid = 1'b1;
    req1_data  = 32'h0202_0202;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outs_both", all_outs(), 64'd0);
    exp_g = '{0, 1, 0};
    s_r0 = c_rdy0; s_r1 = c_rdy1; s_rl0 = c_rl0; s_rl1 = c_rl1;
    n = c_both;
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 20 && !eng_blk_in; w++) tick();
      chk("cont_launch", 64'(eng_blk_in), 64'd1);
      chk("cont_grant", 64'(grant), 64'(exp_g[b]));
      repeat (9) tick();
      for (int s = 0; s < 8; s++) begin
        if (s > 0) tick();
        eng_out_valid = 1'b1;
        eng_sort_out  = 8'(20 - s);
      end
      tick();
      eng_out_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int w = 0; w < 20 && busy; w++) tick();
    tick();
    chk("cont_ready0", 64'(c_rdy0 - s_r0), 64'd16);
    chk("cont_ready1", 64'(c_rdy1 - s_r1), 64'd8);
    chk("cont_both_ready", 64'(c_both - n), 64'd0);
    chk("cont_last0", 64'(c_rl0 - s_rl0), 64'd2);
    chk("cont_last1", 64'(c_rl1 - s_rl1), 64'd1);

    // Reset in the middle of FEED, then a fresh block.
    do_reset();
    s_rl0 = c_rl0; s_rl1 = c_rl1;
    req0_valid = 1'b1;
    req0_data  = 32'h0403_0201;
    tick();
    chk("mid_launch", 64'(eng_blk_in), 64'd1);
    repeat (5) tick();
    chk("mid_in_feed", 64'(req0_ready), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    req0_valid = 1'b0;
    tick();
    chk("mid_no_last", 64'((c_rl0 - s_rl0) + (c_rl1 - s_rl1)), 64'd0);
    chk("mid_idle", 64'(busy), 64'd0);
    run_block(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
